// File: rtl/frame_gather_pkg.sv
// Shared types and sizing for the frame_gather de-interleaving ping-pong buffer.
// A batch arrives as BEATS beats of LANES words and leaves one sample at a time.
package frame_gather_pkg;

    localparam int unsigned WORDSIZE   = 16;
    localparam int unsigned NUMSAMPLES = 32;
    localparam int unsigned LANES      = 4;
    localparam int unsigned BEATS      = NUMSAMPLES / LANES;
    localparam int unsigned IDX_W      = $clog2(NUMSAMPLES);
    localparam int unsigned BEAT_W     = $clog2(BEATS);

    typedef logic [WORDSIZE-1:0] sample_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [BEAT_W-1:0]   beat_t;
    typedef logic                bank_sel_t;

    // Beat k carries samples k, k+BEATS, k+2*BEATS, k+3*BEATS on lanes 0..3.
    function automatic idx_t lane_idx(input beat_t beat, input int unsigned lane);
        return idx_t'(lane * BEATS) + idx_t'(beat);
    endfunction

endpackage

// File: rtl/frame_gather_sample_bank.sv
// One NUMSAMPLES-deep sample bank: strided 4-word write per beat, combinational read.
// Contents are intentionally not reset; the owner's full flag says when they are meaningful.
module frame_gather_sample_bank
    import frame_gather_pkg::*;
(
    input  logic                   clk,
    input  logic                   wr_en,
    input  beat_t                  wr_beat,
    input  sample_t [LANES-1:0]    wr_data,
    input  idx_t                   rd_idx,
    output sample_t                rd_data
);

    sample_t mem_q [NUMSAMPLES];
    sample_t mem_d [NUMSAMPLES];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                mem_d[lane_idx(wr_beat, j)] = wr_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/frame_gather.sv
// Collects 4-word beats into natural sample order in two ping-pong banks and
// streams each completed batch out one sample per cycle with valid/ready.
module frame_gather
    import frame_gather_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_data0,
    input  logic [WORDSIZE-1:0] in_data1,
    input  logic [WORDSIZE-1:0] in_data2,
    input  logic [WORDSIZE-1:0] in_data3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_last,
    output logic                error
);

    logic [1:0] full_q, full_d;
    bank_sel_t  wr_bank_q, wr_bank_d;
    bank_sel_t  rd_bank_q, rd_bank_d;
    beat_t      wr_beat_q, wr_beat_d;
    idx_t       rd_idx_q, rd_idx_d;
    logic       error_q, error_d;

    logic       accept;
    logic       drain;
    logic       fill_done;
    logic       drain_done;
    logic [1:0] bank_we;

    sample_t [LANES-1:0] lane_data;
    sample_t             bank_rd [2];

    assign lane_data = {in_data3, in_data2, in_data1, in_data0};

    for (genvar g = 0; g < 2; g++) begin : g_bank
        frame_gather_sample_bank u_bank (
            .clk     (clk),
            .wr_en   (bank_we[g]),
            .wr_beat (wr_beat_q),
            .wr_data (lane_data),
            .rd_idx  (rd_idx_q),
            .rd_data (bank_rd[g])
        );
    end

    always_comb begin
        in_ready   = !full_q[wr_bank_q];
        out_valid  = full_q[rd_bank_q];
        accept     = in_valid && in_ready;
        drain      = out_valid && out_ready;
        fill_done  = accept && (wr_beat_q == beat_t'(BEATS - 1));
        drain_done = drain && (rd_idx_q == idx_t'(NUMSAMPLES - 1));
        out_data   = out_valid ? bank_rd[rd_bank_q] : '0;
        out_last   = out_valid && (rd_idx_q == idx_t'(NUMSAMPLES - 1));
        error      = error_q;

        bank_we            = '0;
        bank_we[wr_bank_q] = accept;
    end

    // Fill and drain always target different banks, so both flag updates can land together.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_beat_d = wr_beat_q;
        rd_idx_d  = rd_idx_q;
        error_d   = error_q;

        if (accept) begin
            if (fill_done) begin
                wr_beat_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_beat_d = wr_beat_q + 1'b1;
            end
        end

        if (drain) begin
            if (drain_done) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end

        if (in_valid && !in_ready) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_beat_q <= '0;
            rd_idx_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_beat_q <= wr_beat_d;
            rd_idx_q  <= rd_idx_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_frame_gather.sv
// Directed-sequence bench for frame_gather with random sample data, checked
// against a batch-level queue model of the expected output stream.
module tb_frame_gather;
    import frame_gather_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_data;
    logic          out_last;
    logic          error;

    always #5 clk = ~clk;

    frame_gather dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .error     (error)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model: completed batches queued in natural order.
    logic [15:0] m_fill [NUMSAMPLES];
    logic [15:0] m_q [$];
    int          m_beats = 0;
    int          m_pos = 0;
    int          m_full = 0;
    bit          m_err = 0;

    // Stimulus source: the batch currently being sent, in natural order.
    logic [15:0] g_batch [NUMSAMPLES];
    int          g_beat = 0;
    int          g_left = 0;
    bit          g_seq = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_gen_batch();
        for (int i = 0; i < NUMSAMPLES; i++) begin
            g_batch[i] = g_seq ? 16'(i) : 16'($urandom);
        end
    endtask

    task automatic step(input bit want, input bit ordy);
        bit          iv, acc, hs, exp_ready, exp_valid;
        logic [15:0] d [4];
        iv        = want && (g_left > 0);
        exp_ready = (m_full < 2);
        exp_valid = (m_full > 0);
        for (int j = 0; j < 4; j++) begin
            d[j] = (iv && exp_ready) ? g_batch[g_beat + j * BEATS] : 16'($urandom);
        end
        in_valid  = iv;
        out_ready = ordy;
        in_data0  = d[0];
        in_data1  = d[1];
        in_data2  = d[2];
        in_data3  = d[3];
        #4;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_data", 32'(out_data), exp_valid ? 32'(m_q[0]) : 32'd0);
        check("out_last", 32'(out_last), 32'(exp_valid && (m_pos == NUMSAMPLES - 1)));
        check("error", 32'(error), 32'(m_err));
        acc = iv && exp_ready;
        hs  = exp_valid && ordy;
        @(posedge clk);
        #1;
        if (iv && !exp_ready) m_err = 1;
        if (acc) begin
            for (int j = 0; j < 4; j++) m_fill[m_beats + j * BEATS] = d[j];
            m_beats++;
            if (m_beats == BEATS) begin
                for (int i = 0; i < NUMSAMPLES; i++) m_q.push_back(m_fill[i]);
                m_full++;
                m_beats = 0;
            end
            g_beat++;
            if (g_beat == BEATS) begin
                g_beat = 0;
                g_left--;
                new_gen_batch();
            end
        end
        if (hs) begin
            void'(m_q.pop_front());
            m_pos++;
            if (m_pos == NUMSAMPLES) begin
                m_pos = 0;
                m_full--;
            end
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        m_q.delete();
        m_beats = 0;
        m_pos   = 0;
        m_full  = 0;
        m_err   = 0;
        g_beat  = 0;
        g_left  = 0;
        new_gen_batch();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit want, input bit ordy);
        for (int i = 0; i < n; i++) step(want, ordy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle behaviour
        g_seq = 1;
        apply_reset();
        run(2, 0, 0);

        // Single batch, k + 8j pattern, consumer always ready
        g_left = 1;
        new_gen_batch();
        run(8, 1, 1);
        run(34, 0, 1);

        // Back-pressure: out_ready toggles every cycle
        g_seq  = 0;
        g_left = 1;
        new_gen_batch();
        run(8, 1, 1);
        for (int i = 0; i < 70; i++) step(0, i[0]);

        // Ping-pong: three batches with in_valid held high
        g_left = 3;
        new_gen_batch();
        run(130, 1, 1);

        // Overflow: fill both banks, then one rejected beat
        g_left = 2;
        new_gen_batch();
        run(20, 1, 0);
        g_left = 1;
        run(1, 1, 0);
        run(3, 0, 0);
        run(110, 1, 1);

        // Reset while batch 1 drains and batch 2 is half written
        g_left = 2;
        new_gen_batch();
        run(13, 1, 1);
        apply_reset();
        g_seq  = 1;
        g_left = 1;
        new_gen_batch();
        run(8, 1, 1);
        run(34, 0, 1);

        // Fill-complete of batch 2 on the same edge as batch 1's last handshake
        g_seq  = 0;
        g_left = 2;
        new_gen_batch();
        run(8, 1, 1);
        run(24, 0, 1);
        run(8, 1, 1);
        run(40, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_gather.md
# frame_gather

Downstream stage of the 4-word-per-cycle sample reader. Accepts beats of four 16-bit words (sample k, k+8, k+16, k+24 of a 32-sample batch) and de-interleaves them into natural sample order in a two-bank ping-pong buffer. Streams each completed batch out one sample per cycle under a valid/ready handshake. Decouples the wide, bursty reader from the serial processing chain behind it.

## Interface
- WORDSIZE, 16, bits per sample
- NUMSAMPLES, 32, samples per batch; must be a multiple of 4
- BEATS, NUMSAMPLES/4, input beats per batch (8)
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input beat present
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data0..in_data3  input  WORDSIZE each  samples k, k+BEATS, k+2·BEATS, k+3·BEATS for beat k
- out_valid  output  1  out_data holds a sample
- out_ready  input  1  consumer takes sample when out_valid && out_ready
- out_data  output  WORDSIZE  current sample, natural order
- out_last  output  1  high with sample NUMSAMPLES-1 of a batch
- error  output  1  sticky overflow flag

## Operation
- Two banks, each NUMSAMPLES × WORDSIZE, plus a per-bank full flag. Write pointer: wr_bank, beat counter wr_beat (0..BEATS-1). Read pointer: rd_bank, rd_idx (0..NUMSAMPLES-1).
- Reset: both full flags 0; wr_bank = rd_bank = 0; wr_beat = rd_idx = 0; error = 0; out_valid = 0; out_last = 0; out_data = 0; in_ready = 1. Bank contents are not cleared.
- in_ready = !full[wr_bank].
- Accepted beat k: bank[wr_bank][k + j·BEATS] ← in_dataj for j = 0..3. When k = BEATS-1: full[wr_bank] ← 1, wr_bank toggles, wr_beat ← 0. Otherwise wr_beat increments.
- out_valid = full[rd_bank]. out_data = bank[rd_bank][rd_idx] when out_valid, else 0. out_last = out_valid && rd_idx = NUMSAMPLES-1.
- Handshake out_valid && out_ready: rd_idx increments. At NUMSAMPLES-1: full[rd_bank] ← 0, rd_bank toggles, rd_idx ← 0.
- out_data/out_last stay stable while out_valid && !out_ready.
- Overflow: in_valid && !in_ready sets error. error stays set until reset. The beat is dropped and no state changes.
- There is no explicit FSM. Each bank cycles EMPTY → FILLING → FULL → DRAINING → EMPTY, driven by the pointers and full flags.

## Timing
- Latency: the last beat of a batch is accepted at edge T, and out_valid is high after edge T (first sample visible the cycle after acceptance).
- Read path is combinational from bank registers. Only the pointers and flags are registered.
- Throughput: input at most 1 beat/cycle, output at most 1 sample/cycle. A batch drains in NUMSAMPLES cycles with out_ready held high, so upstream stalls under steady load.
- Freed bank: in_ready rises the cycle after the edge that clears full. There is no same-cycle bypass.
- Simultaneous fill-complete of one bank and drain-complete of the other on the same edge is legal. Both flags update independently.
- Both banks full: in_ready = 0 until a bank drains.
- Reset mid-batch: partial input batch and undrained output discarded; all outputs take reset values asynchronously.

## Structure
- Shared package: WORDSIZE, NUMSAMPLES, BEATS, a sample word type, and a bank-select type (1 bit).
- Sub-module: sample_bank. It holds one NUMSAMPLES × WORDSIZE register bank with a 4-word strided write port (beat index, write enable) and one combinational read port (index). It is instantiated twice. Top level holds pointers, full flags, handshake and error.

## Test plan
- Single batch: feed 8 beats on consecutive cycles with in_dataj = k + 8j, out_ready = 1. Response: out_data = 0,1,…,31 on 32 consecutive cycles starting the cycle after beat 7. out_last is high only with 31. error = 0.
- Back-pressure: same batch with out_ready toggling every cycle. Response: sequence is still 0..31 with no repeats or skips. out_data is stable during every out_ready = 0 cycle.
- Ping-pong fill: 3 batches pushed with in_valid held high and out_ready = 1. Response: in_ready drops after batch 2 fills while batch 1 drains. in_ready rises the cycle after sample 31 of batch 1 is taken. All 96 samples come out in order.
- Overflow: fill both banks with out_ready = 0, then assert in_valid for one cycle. Response: error = 1 and stays 1. The dropped beat never appears on out_data.
- Reset mid-operation: assert rst_n = 0 after beat 4 of batch 2 while batch 1 is draining. Response: out_valid = 0, in_ready = 1, error = 0 immediately. A fresh batch afterwards comes out 0..31 correctly.
- Simultaneous events: time batch 2's final beat to land on the same edge as batch 1's last handshake. Response: out_valid stays high across the boundary, and out_data goes 31 → 0 of batch 2 with no gap.
